cardinal_processor: RTL and testbench

// 4-stage (IF/ID/EX/WB) in-order pipelined 64-bit SIMD core, big-endian bit numbering ([0] = MSB).

---
 rtl/cardinal_processor.sv | 227 ++++++++++++++++++++++
 tb/tb_cardinal_processor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_processor.sv
// Four-stage IF/ID/EX/WB 64-bit SIMD core.
// Lane-wise ALU, byte-masked writeback, branches resolved in ID.
package cardinal_pkg;
  typedef struct packed {
    logic        rt;
    logic        ld;
    logic        st;
    logic [5:0]  fn;
    logic [1:0]  ww;
    logic [2:0]  ppp;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] imm;
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] vd;
  } id_ex_t;

  typedef struct packed {
    logic        we;
    logic        ld;
    logic [4:0]  rd;
    logic [63:0] data;
  } ex_wb_t;
endpackage

module cardinal_processor
  import cardinal_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [63:0] dataIn,
  output logic [31:0] pc,
  output logic [63:0] dataOut,
  output logic [31:0] memAddr,
  output logic        memEn,
  output logic        memWrEn
);

  function automatic logic [63:0] lane_alu(
    input logic [5:0]  f,
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w
  );
    logic [63:0] m, x, y, s, r;
    int sh;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x  = a & m;
    y  = b & m;
    sh = 32'(y[5:0]) & (w - 1);
    s  = x << (64 - w);
    s  = $signed(s) >>> (64 - w);
    unique case (f)
      6'd6:    r = x + y;
      6'd7:    r = x - y;
      6'd10:   r = x << sh;
      6'd11:   r = x >> sh;
      6'd12:   r = $signed(s) >>> sh;
      default: r = '0;
    endcase
    return r & m;
  endfunction

  // Lanes are independent, so carries and shifts never cross a boundary.
  function automatic logic [63:0] simd(
    input logic [5:0]  f,
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w
  );
    logic [63:0] r, t;
    r = '0;
    for (int i = 0; i < 64 / w; i++) begin
      t = lane_alu(f, a >> (i * w), b >> (i * w), w);
      r = r | (t << (i * w));
    end
    return r;
  endfunction

  function automatic logic [63:0] fwd(
    input logic [4:0]  a,
    input logic [63:0] v,
    input logic        en,
    input logic [4:0]  wd,
    input logic [63:0] wv
  );
    return (en && wd == a) ? wv : v;
  endfunction

  logic [63:0] rf [32];
  logic [31:0] ir;
  id_ex_t      id_ex, id_nx;
  ex_wb_t      ex_wb, ex_nx;

  logic        wb_w;
  logic [63:0] wb_val;

  logic [5:0]  op;
  logic [4:0]  i_rd, i_ra, i_rb;
  logic        fn_ok, is_r, is_ld, is_st;
  logic        is_bez, is_bnez;
  logic [63:0] id_vd;
  logic        stall, take;

  logic [63:0] fa, fb, fd, sv, alu, res;
  logic [7:0]  bm;

  assign wb_w   = ex_wb.we && ex_wb.rd != 5'd0;
  assign wb_val = ex_wb.ld ? dataIn : ex_wb.data;

  assign op   = ir[31:26];
  assign i_rd = ir[25:21];
  assign i_ra = ir[20:16];
  assign i_rb = ir[15:11];

  always_comb begin
    fn_ok   = ir[5:0] inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
                              6'd6, 6'd7, 6'd10, 6'd11, 6'd12};
    is_r    = op == 6'b101010 && fn_ok;
    is_ld   = op == 6'b100000;
    is_st   = op == 6'b100001;
    is_bez  = op == 6'b100010;
    is_bnez = op == 6'b100011;

    id_vd = (i_rd == 5'd0) ? '0
          : fwd(i_rd, rf[i_rd], wb_w, ex_wb.rd, wb_val);

    stall = (is_bez || is_bnez) && (id_ex.rt || id_ex.ld)
         && id_ex.rd != 5'd0 && id_ex.rd == i_rd;
    take  = !stall && ((is_bez && id_vd == '0)
                    || (is_bnez && id_vd != '0));

    id_nx     = '0;
    id_nx.rt  = is_r;
    id_nx.ld  = is_ld;
    id_nx.st  = is_st;
    id_nx.fn  = ir[5:0];
    id_nx.ww  = ir[7:6];
    id_nx.ppp = ir[10:8];
    id_nx.rd  = i_rd;
    id_nx.ra  = i_ra;
    id_nx.rb  = i_rb;
    id_nx.imm = ir[15:0];
    id_nx.va  = (i_ra == 5'd0) ? '0
              : fwd(i_ra, rf[i_ra], wb_w, ex_wb.rd, wb_val);
    id_nx.vb  = (i_rb == 5'd0) ? '0
              : fwd(i_rb, rf[i_rb], wb_w, ex_wb.rd, wb_val);
    id_nx.vd  = id_vd;
  end

  always_comb begin
    fa = fwd(id_ex.ra, id_ex.va, wb_w, ex_wb.rd, wb_val);
    fb = fwd(id_ex.rb, id_ex.vb, wb_w, ex_wb.rd, wb_val);
    fd = fwd(id_ex.rd, id_ex.vd, wb_w, ex_wb.rd, wb_val);

    unique case (id_ex.ww)
      2'b00: sv = simd(id_ex.fn, fa, fb, 8);
      2'b01: sv = simd(id_ex.fn, fa, fb, 16);
      2'b10: sv = simd(id_ex.fn, fa, fb, 32);
      2'b11: sv = simd(id_ex.fn, fa, fb, 64);
    endcase

    case (id_ex.fn)
      6'd1:    alu = fa & fb;
      6'd2:    alu = fa | fb;
      6'd3:    alu = fa ^ fb;
      6'd4:    alu = ~fa;
      6'd5:    alu = fa;
      default: alu = sv;
    endcase

    // bm[7] is byte 0, the most significant byte.
    case (id_ex.ppp)
      3'b000:  bm = 8'hFF;
      3'b001:  bm = 8'hF0;
      3'b010:  bm = 8'h0F;
      3'b011:  bm = 8'hAA;
      3'b100:  bm = 8'h55;
      default: bm = 8'h00;
    endcase

    res = fd;
    for (int j = 0; j < 8; j++)
      if (bm[j]) res[8*j +: 8] = alu[8*j +: 8];

    ex_nx      = '0;
    ex_nx.we   = id_ex.rt || id_ex.ld;
    ex_nx.ld   = id_ex.ld;
    ex_nx.rd   = id_ex.rd;
    ex_nx.data = res;
  end

  assign memEn   = id_ex.ld || id_ex.st;
  assign memWrEn = id_ex.st;
  assign memAddr = memEn ? {16'b0, id_ex.imm} : '0;
  assign dataOut = id_ex.st ? fd : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      ir    <= '0;
      id_ex <= '0;
      ex_wb <= '0;
    end else begin
      ex_wb <= ex_nx;
      if (stall) begin
        id_ex <= '0;
      end else begin
        id_ex <= id_nx;
        pc    <= take ? {16'b0, ir[15:0]} : pc + 32'd4;
        ir    <= take ? '0 : instruction;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_w) begin
      rf[ex_wb.rd] <= wb_val;
    end
  end

endmodule

// File: tb/tb_cardinal_processor.sv
// Directed bench for cardinal_processor.
// Models imem/dmem; checks bus activity, pc flow and stored results.
module tb_cardinal_processor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, pc, memAddr;
  logic [63:0] dataIn, dataOut;
  logic        memEn, memWrEn;

  logic [31:0] imem [512];
  logic [63:0] dmem [512];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  cardinal_processor dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .dataIn      (dataIn),
    .pc          (pc),
    .dataOut     (dataOut),
    .memAddr     (memAddr),
    .memEn       (memEn),
    .memWrEn     (memWrEn)
  );

  always #5 clk = ~clk;

  assign instruction = imem[pc[10:2]];

  function automatic logic [63:0] dinit(input int i);
    case (i)
      0:       return 64'h00FF_0001_7FFF_FFFF;
      1:       return 64'h0001_0001_0001_0001;
      3:       return 64'h1111_1111_2222_2222;
      4:       return 64'h0000_0001_F000_0001;
      6:       return 64'h0500_0300_0100_FF10;
      8:       return 64'h8000_0000_0000_0040;
      9:       return 64'h0909_0909_0909_0909;
      14:      return 64'h0;
      19:      return 64'h5;
      default: return 64'hA5A5_A5A5_A5A5_A5A5;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) dmem[i] <= dinit(i);
      dataIn <= '0;
    end else if (memEn) begin
      if (memWrEn) dmem[memAddr[8:0]] <= dataOut;
      else         dataIn <= dmem[memAddr[8:0]];
    end
  end

  function automatic logic [31:0] rop(input logic [5:0] f,
      input int d, input int a, input int b,
      input logic [2:0] p, input logic [1:0] w);
    return {6'b101010, 5'(d), 5'(a), 5'(b), p, w, f};
  endfunction

  function automatic logic [31:0] mop(input logic [5:0] o,
      input int d, input logic [15:0] im);
    return {o, 5'(d), 5'd0, im};
  endfunction

  localparam logic [5:0] VLD = 6'b100000, VSD = 6'b100001;
  localparam logic [5:0] BEZ = 6'b100010, BNZ = 6'b100011;
  localparam logic [5:0] AND = 6'd1, XOR = 6'd3, NOT = 6'd4;
  localparam logic [5:0] MOV = 6'd5, ADD = 6'd6, SUB = 6'd7;
  localparam logic [5:0] SLL = 6'd10, SRL = 6'd11, SRA = 6'd12;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) imem[i] = '0;
    imem[0]  = mop(VLD, 1, 16'd0);
    imem[1]  = mop(VLD, 2, 16'd1);
    imem[2]  = rop(ADD, 3, 1, 2, 3'b000, 2'b01);
    imem[3]  = mop(VSD, 3, 16'd2);
    imem[4]  = mop(VLD, 6, 16'd3);
    imem[5]  = mop(VLD, 7, 16'd4);
    imem[6]  = rop(ADD, 6, 6, 7, 3'b010, 2'b11);
    imem[7]  = mop(VSD, 6, 16'd5);
    imem[8]  = mop(VLD, 8, 16'd6);
    imem[9]  = rop(SUB, 9, 8, 2, 3'b000, 2'b00);
    imem[10] = mop(VSD, 9, 16'd7);
    imem[11] = mop(VLD, 4, 16'd14);
    imem[12] = mop(BEZ, 4, 16'h0040);
    imem[13] = rop(MOV, 20, 1, 0, 3'b000, 2'b11);
    imem[16] = mop(VSD, 20, 16'd11);
    imem[17] = rop(MOV, 0, 1, 0, 3'b000, 2'b11);
    imem[18] = mop(VSD, 0, 16'd12);
    imem[19] = mop(VLD, 10, 16'd8);
    imem[20] = mop(VLD, 11, 16'd9);
    imem[21] = rop(SRA, 12, 10, 11, 3'b000, 2'b00);
    imem[22] = mop(VSD, 12, 16'd10);
    imem[23] = mop(BNZ, 0, 16'h0100);
    imem[24] = rop(SRL, 13, 10, 11, 3'b000, 2'b01);
    imem[25] = mop(VSD, 13, 16'd15);
    imem[26] = rop(NOT, 14, 0, 0, 3'b011, 2'b11);
    imem[27] = mop(VSD, 14, 16'd16);
    imem[28] = rop(XOR, 15, 1, 2, 3'b100, 2'b11);
    imem[29] = mop(VSD, 15, 16'd17);
    imem[30] = rop(MOV, 3, 0, 0, 3'b101, 2'b11);
    imem[31] = mop(VSD, 3, 16'd18);
    imem[32] = rop(SLL, 24, 11, 11, 3'b000, 2'b10);
    imem[33] = mop(VSD, 24, 16'd22);
    imem[34] = rop(AND, 25, 1, 11, 3'b000, 2'b11);
    imem[35] = mop(VSD, 25, 16'd23);
    imem[36] = mop(VLD, 16, 16'd19);
    imem[37] = mop(BNZ, 16, 16'h0100);
    imem[38] = rop(MOV, 22, 1, 0, 3'b000, 2'b11);
    imem[64] = mop(VSD, 22, 16'd20);
    imem[65] = mop(VSD, 1, 16'd21);

    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_memEn", 64'(memEn), 64'h0);
    chk("rst_memWrEn", 64'(memWrEn), 64'h0);
    chk("rst_memAddr", 64'(memAddr), 64'h0);
    chk("rst_dataOut", dataOut, 64'h0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    cyc = 0;
    chk("c0_pc", 64'(pc), 64'h0);
    step();
    chk("c1_pc", 64'(pc), 64'h4);
    chk("c1_memEn", 64'(memEn), 64'h0);
    step();
    chk("c2_pc", 64'(pc), 64'h8);
    chk("c2_ld_en", 64'(memEn), 64'h1);
    chk("c2_ld_wr", 64'(memWrEn), 64'h0);
    chk("c2_ld_addr", 64'(memAddr), 64'h0);

    run_to(5);
    chk("c5_st_wr", 64'(memWrEn), 64'h1);
    chk("c5_st_addr", 64'(memAddr), 64'h2);
    chk("c5_st_data", dataOut, 64'h0100_0002_8000_0000);

    run_to(12);
    chk("c12_ldu_addr", 64'(memAddr), 64'h7);
    chk("c12_ldu_data", dataOut, 64'h05FF_03FF_01FF_FF0F);

    run_to(13);
    chk("c13_stall_pc", 64'(pc), 64'h34);
    chk("c13_ld_addr", 64'(memAddr), 64'hE);
    step();
    chk("c14_hold_pc", 64'(pc), 64'h34);
    chk("c14_bubble", 64'(memEn), 64'h0);
    step();
    chk("c15_taken_pc", 64'(pc), 64'h40);

    run_to(24);
    chk("c24_bnez_r0", 64'(pc), 64'h64);
    run_to(38);
    chk("c38_hold_pc", 64'(pc), 64'h98);
    step();
    chk("c39_taken_pc", 64'(pc), 64'h100);

    run_to(60);
    chk("m2_vadd16", dmem[2], 64'h0100_0002_8000_0000);
    chk("m5_vadd64_lo", dmem[5], 64'h1111_1111_1222_2223);
    chk("m7_vsub8", dmem[7], 64'h05FF_03FF_01FF_FF0F);
    chk("m11_squash", dmem[11], 64'h0);
    chk("m12_r0", dmem[12], 64'h0);
    chk("m10_vsra8", dmem[10], 64'hC000_0000_0000_0020);
    chk("m15_vsrl16", dmem[15], 64'h0040_0000_0000_0000);
    chk("m16_even", dmem[16], 64'hFF00_FF00_FF00_FF00);
    chk("m17_odd", dmem[17], 64'h00FE_0000_00FE_00FE);
    chk("m18_nomask", dmem[18], 64'h0100_0002_8000_0000);
    chk("m22_vsll32", dmem[22], 64'h1212_1200_1212_1200);
    chk("m23_vand", dmem[23], 64'h0009_0001_0909_0909);
    chk("m20_squash2", dmem[20], 64'h0);
    chk("m21_r1", dmem[21], 64'h00FF_0001_7FFF_FFFF);
    chk("m24_untouched", dmem[24], 64'hA5A5_A5A5_A5A5_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
